// File: rtl/imem_loader.sv
// Instruction memory bootloader: receives a length-prefixed byte frame
// and writes big-endian 32-bit words into the instruction RAM.
module imem_loader #(
   parameter int ADDR_W = 9,
   parameter int DEPTH  = 512
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic              cpu_hold
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERROR
   } state_t;

   localparam logic [15:0] MAXLEN = DEPTH[15:0];

   state_t              state;
   state_t              nxt;
   logic [15:0]         len;
   logic [15:0]         len_lo_val;
   logic [ADDR_W-1:0]   word_idx;
   logic [1:0]          bcnt;
   logic [23:0]         wbuf;
   logic [7:0]          xor_acc;
   logic                acc;
   logic                last_word;
   logic                restart;

   assign acc        = byte_valid & byte_ready;
   assign len_lo_val = {len[15:8], byte_data};
   assign last_word  =
      ({{(16-ADDR_W){1'b0}}, word_idx} + 16'd1) == len;
   assign restart    = start &
      (state == S_IDLE || state == S_DONE || state == S_ERROR);

   assign busy     = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                     (state == S_DATA)   || (state == S_CSUM);
   assign done     = (state == S_DONE);
   assign error    = (state == S_ERROR);
   assign cpu_hold = busy | error;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt        = state;
      byte_ready = 1'b0;
      unique case (state)
         S_IDLE: if (start) nxt = S_LEN_HI;
         S_LEN_HI: begin
            byte_ready = 1'b1;
            if (byte_valid) nxt = S_LEN_LO;
         end
         S_LEN_LO: begin
            byte_ready = 1'b1;
            if (byte_valid) begin
               if (len_lo_val > MAXLEN)     nxt = S_ERROR;
               else if (len_lo_val == 16'd0) nxt = S_CSUM;
               else                          nxt = S_DATA;
            end
         end
         S_DATA: begin
            byte_ready = 1'b1;
            if (byte_valid && bcnt == 2'd3 && last_word) nxt = S_CSUM;
         end
         S_CSUM: begin
            byte_ready = 1'b1;
            if (byte_valid)
               nxt = (byte_data == xor_acc) ? S_DONE : S_ERROR;
         end
         S_DONE, S_ERROR: if (start) nxt = S_LEN_HI;
         default: nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len       <= '0;
         word_idx  <= '0;
         bcnt      <= '0;
         wbuf      <= '0;
         xor_acc   <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_we <= 1'b0;
         if (restart) begin
            len      <= '0;
            word_idx <= '0;
            bcnt     <= '0;
            wbuf     <= '0;
            xor_acc  <= '0;
         end
         if (acc && state == S_LEN_HI) len[15:8] <= byte_data;
         if (acc && state == S_LEN_LO) len[7:0]  <= byte_data;
         if (acc && state == S_DATA) begin
            xor_acc <= xor_acc ^ byte_data;
            wbuf    <= {wbuf[15:0], byte_data};
            bcnt    <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
               mem_we    <= 1'b1;
               mem_addr  <= word_idx;
               mem_wdata <= {wbuf, byte_data};
               // hold the index on the final word so it never wraps
               if (!last_word) word_idx <= word_idx + 1'b1;
            end
         end
      end
   end

endmodule
